adc_lock_monitor: RTL and testbench

- Upstream status stage for the ADC-lock software register. Runs in the user_clk domain and takes the ADC interface MMCM lock signal, which is asynchronous to user_clk.
- Debounces that signal into a stable-lock qualifier and counts lock-loss events.
- Packs the results into a 32-bit status word. That word drives user_data_in of the adc_in_locked simulink2ppc register so software can read it over OPB.
- A software clear strobe resets the sticky loss flag and the loss counter.

---
 rtl/adc_lock_monitor.sv | 145 ++++++++++++++
 tb/tb_adc_lock_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adc_lock_monitor.sv
// ADC-lock status stage: synchronizes the asynchronous MMCM lock, qualifies it
// with a settle counter, counts lock-loss events and packs everything into a
// 32-bit status word for the software-readable lock register.
module adc_lock_monitor #(
  parameter int unsigned LOCK_SETTLE = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        mmcm_locked_in,
  input  logic        clear_in,
  output logic        lock_stable,
  output logic [31:0] status_word
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // settle_cnt already counts the cycle on which it is sampled, so the
  // LOCK_SETTLE-th consecutive locked cycle is the one that sees LOCK_SETTLE-1.
  localparam logic [15:0]          SETTLE_LAST = 16'(LOCK_SETTLE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic                 sync_meta;
  logic                 lock_s;
  logic                 clr_d;
  logic                 clr_pulse;

  state_t               state;
  state_t               state_next;
  logic [15:0]          settle_cnt;
  logic [15:0]          settle_next;
  logic                 loss_evt;

  logic [CNT_WIDTH-1:0] loss_cnt;
  logic [CNT_WIDTH-1:0] loss_next;
  logic                 sticky_loss;
  logic                 sticky_next;
  logic [31:0]          status_next;

  // Two-flop synchronizer for the asynchronous MMCM lock.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      sync_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync_meta <= mmcm_locked_in;
      lock_s    <= sync_meta;
    end
  end

  // Delayed copy of the software clear level for rising-edge detection.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      clr_d <= 1'b0;
    end else begin
      clr_d <= clear_in;
    end
  end

  assign clr_pulse = clear_in & ~clr_d;

  // Lock qualification next-state: settle on sustained lock, flag loss from LOCKED.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    loss_evt    = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (lock_s) begin
          state_next  = SETTLING;
          settle_next = 16'd1;
        end
      end
      SETTLING: begin
        if (!lock_s) begin
          state_next = UNLOCKED;
        end else if (settle_cnt >= SETTLE_LAST) begin
          state_next = LOCKED;
        end else begin
          settle_next = settle_cnt + 16'd1;
        end
      end
      LOCKED: begin
        if (!lock_s) begin
          state_next = UNLOCKED;
          loss_evt   = 1'b1;
        end
      end
      default: begin
        state_next = UNLOCKED;
      end
    endcase
  end

  // Loss bookkeeping: clear first, then account the event so none is dropped.
  always_comb begin
    loss_next   = loss_cnt;
    sticky_next = sticky_loss;
    if (clr_pulse) begin
      loss_next   = '0;
      sticky_next = 1'b0;
    end
    if (loss_evt) begin
      sticky_next = 1'b1;
      if (loss_next != CNT_MAX) begin
        loss_next = loss_next + CNT_ONE;
      end
    end
  end

  // Status word assembled from next-state values so every field is coherent.
  always_comb begin
    status_next        = '0;
    status_next[0]     = lock_s;
    status_next[1]     = (state_next == LOCKED);
    status_next[2]     = sticky_next;
    status_next[5:4]   = state_next;
    status_next[31:16] = loss_next;
  end

  // State, counters and registered outputs.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state       <= UNLOCKED;
      settle_cnt  <= '0;
      loss_cnt    <= '0;
      sticky_loss <= 1'b0;
      status_word <= '0;
      lock_stable <= 1'b0;
    end else begin
      state       <= state_next;
      settle_cnt  <= settle_next;
      loss_cnt    <= loss_next;
      sticky_loss <= sticky_next;
      status_word <= status_next;
      lock_stable <= (state_next == LOCKED);
    end
  end

endmodule

// File: tb/tb_adc_lock_monitor.sv
// Directed bench for adc_lock_monitor with LOCK_SETTLE=8: a vector table for
// reset, first lock and a single-cycle dropout, then hand sequences for the
// settling glitch, clear handling, mid-run reset and counter saturation.
module tb_adc_lock_monitor;

  logic        clk;
  logic        rst;
  logic        mmcm;
  logic        clr;
  logic        lock_stable;
  logic [31:0] status_word;

  int unsigned total;
  int unsigned passed;

  typedef struct {
    logic        rst;
    logic        mmcm;
    logic        clr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [27];

  adc_lock_monitor #(
    .LOCK_SETTLE (8),
    .CNT_WIDTH   (16)
  ) dut (
    .user_clk       (clk),
    .user_rst       (rst),
    .mmcm_locked_in (mmcm),
    .clear_in       (clr),
    .lock_stable    (lock_stable),
    .status_word    (status_word)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    total++;
    if (status_word !== exp) begin
      $display("FAIL %s: status_word=%h expected %h", name, status_word, exp);
    end else begin
      passed++;
    end
    total++;
    if (lock_stable !== exp[1]) begin
      $display("FAIL %s: lock_stable=%b expected %b", name, lock_stable, exp[1]);
    end else begin
      passed++;
    end
  endtask

  // One-cycle dropout from LOCKED followed by a full relock; c is the count after the loss.
  task automatic loss_and_relock(input logic [15:0] c, input string tag);
    mmcm = 1'b0;
    tick();
    mmcm = 1'b1;
    tick();
    tick();
    check({tag, "_unlocked"}, {c, 16'h0004});
    tick();
    check({tag, "_settling"}, {c, 16'h0015});
    repeat (6) tick();
    tick();
    check({tag, "_relocked"}, {c, 16'h0027});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    mmcm   = 1'b0;
    clr    = 1'b0;
    total  = 0;
    passed = 0;

    // Reset, first lock (raised at row 4), dropout (row 15) and relock.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000};
    for (int i = 6; i <= 12; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0000_0011};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_0023};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0023};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0023};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0000_0023};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0001_0004};
    for (int i = 18; i <= 24; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0001_0015};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 32'h0001_0027};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 32'h0001_0027};

    for (int i = 0; i < 27; i++) begin
      rst  = tbl[i].rst;
      mmcm = tbl[i].mmcm;
      clr  = tbl[i].clr;
      tick();
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Loss, then a dropout while settle_cnt=5: no extra loss, full restart.
    mmcm = 1'b0; tick();
    mmcm = 1'b1; tick();
    tick(); check("glitch_loss", 32'h0002_0004);
    tick(); check("glitch_settle1", 32'h0002_0015);
    tick();
    tick();
    mmcm = 1'b0; tick();
    mmcm = 1'b1; tick(); check("glitch_settle5", 32'h0002_0015);
    tick(); check("glitch_drop", 32'h0002_0004);
    tick(); check("glitch_restart", 32'h0002_0015);
    repeat (5) tick();
    tick(); check("glitch_7th", 32'h0002_0015);
    tick(); check("glitch_8th", 32'h0002_0027);

    // Clear rising edge on the same cycle as a loss event.
    mmcm = 1'b0; tick();
    mmcm = 1'b1; tick();
    clr  = 1'b1; tick(); check("clr_and_loss", 32'h0001_0004);
    tick(); check("clr_and_loss_next", 32'h0001_0015);
    clr = 1'b0;
    repeat (6) tick();
    tick(); check("clr_and_loss_relock", 32'h0001_0027);

    // Clear alone leaves the FSM in LOCKED; held level clears only once.
    clr = 1'b1; tick(); check("clr_rise", 32'h0000_0023);
    loss_and_relock(16'h0001, "held1");
    loss_and_relock(16'h0002, "held2");
    repeat (3) tick();
    check("held_end", 32'h0002_0027);
    clr = 1'b0; tick(); check("clr_fall", 32'h0002_0027);

    loss_and_relock(16'h0003, "loss3");
    loss_and_relock(16'h0004, "loss4");
    loss_and_relock(16'h0005, "loss5");

    // Reset mid-operation while LOCKED with count=5, lock still asserted.
    rst = 1'b1; tick(); check("rst_mid", 32'h0000_0000);
    rst = 1'b0; tick(); check("rst_rel0", 32'h0000_0000);
    tick(); check("rst_rel1", 32'h0000_0000);
    tick(); check("rst_settle", 32'h0000_0011);
    repeat (5) tick();
    tick(); check("rst_settle_last", 32'h0000_0011);
    tick(); check("rst_relocked", 32'h0000_0023);

    // Saturation: preload 0xFFFE, then three losses.
    force dut.loss_cnt = 16'hFFFE;
    tick();
    release dut.loss_cnt;
    tick(); check("sat_preload", 32'hFFFE_0023);
    loss_and_relock(16'hFFFF, "sat1");
    loss_and_relock(16'hFFFF, "sat2");
    loss_and_relock(16'hFFFF, "sat3");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
